// File: rtl/cms_axis_downsizer_if.sv
// AXI-Stream beat bundle shared by the wide and narrow sides of the downsizer.
// Signals: tvalid, tready, tdata[W-1:0], tlast; master drives all but tready.
interface cms_axis_downsizer_if #(
    parameter int W = 64
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/cms_axis_downsizer.sv
// Wide-to-narrow AXI-Stream downsizer with a small input FIFO (lane 0 first).
// Ports: clk, rst_n (async low), clr (sync flush), s_axis (slave, IN_WIDTH),
//   m_axis (master, OUT_WIDTH), fifo_level, packet_count.
// Optional macro CMS_DOWNSIZER_STATS_EN adds beat_count and stall_count.
module cms_axis_downsizer #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    cms_axis_downsizer_if.slave        s_axis,
    cms_axis_downsizer_if.master       m_axis,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [31:0]                packet_count
`ifdef CMS_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]                beat_count,
    output logic [31:0]                stall_count
`endif
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int IW    = $clog2(RATIO);
    localparam int LW    = PW + 1;

    typedef logic [RATIO-1:0][OUT_WIDTH-1:0] lanes_t;

    lanes_t             r_data [DEPTH];
    logic [DEPTH-1:0]   r_last;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [LW-1:0]      r_level;
    logic [IW-1:0]      r_idx;
    logic [31:0]        r_pkt;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_hs;
    logic               w_lane_end;
    logic               w_pop;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_push     = s_axis.tvalid && s_axis.tready;
    assign w_hs       = m_axis.tvalid && m_axis.tready;
    assign w_lane_end = (r_idx == IW'(RATIO - 1));
    assign w_pop      = w_hs && w_lane_end;

    // Full blocks acceptance even when a pop frees a slot this cycle.
    assign s_axis.tready = !w_full && !clr;

    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : r_data[r_rptr][r_idx];
    assign m_axis.tlast  = !w_empty && r_last[r_rptr] && w_lane_end;

    assign fifo_level   = r_level;
    assign packet_count = r_pkt;

    // Storage needs no reset: empty entries are never presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= s_axis.tdata;
            r_last[r_wptr] <= s_axis.tlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_idx   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_hs) begin
                r_idx <= w_lane_end ? '0 : r_idx + IW'(1);
            end
        end
    end

    // Counts interface handshakes, so it is not affected by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt <= '0;
        end else if (w_hs && m_axis.tlast) begin
            r_pkt <= r_pkt + 32'd1;
        end
    end

`ifdef CMS_DOWNSIZER_STATS_EN
    logic [31:0] r_beats;
    logic [31:0] r_stalls;

    assign beat_count  = r_beats;
    assign stall_count = r_stalls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats  <= '0;
            r_stalls <= '0;
        end else begin
            if (w_hs) begin
                r_beats <= r_beats + 32'd1;
            end
            if (m_axis.tvalid && !m_axis.tready) begin
                r_stalls <= r_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// Directed self-checking bench for cms_axis_downsizer (512 -> 64, depth 4).
// Ports: none; drives the DUT through two interface instances.
module tb_cms_axis_downsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [2:0]  fifo_level;
    logic [31:0] packet_count;
`ifdef CMS_DOWNSIZER_STATS_EN
    logic [31:0] beat_count;
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cms_axis_downsizer_if #(.W(512)) s_if ();
    cms_axis_downsizer_if #(.W(64))  m_if ();

    cms_axis_downsizer #(
        .IN_WIDTH  (512),
        .OUT_WIDTH (64),
        .DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .fifo_level   (fifo_level),
        .packet_count (packet_count)
`ifdef CMS_DOWNSIZER_STATS_EN
        ,
        .beat_count   (beat_count),
        .stall_count  (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk(input logic [63:0] base);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*64 +: 64] = base + 64'(i);
        end
        return r;
    endfunction

    logic [63:0] pat;
    int          e;
    int          p;
    logic        hs;
    logic        acc;

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_mdata", m_if.tdata, 64'd0);
        chk("rst_mlast", 64'(m_if.tlast), 64'd0);
        chk("rst_pkt", 64'(packet_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_srdy", 64'(s_if.tready), 64'd1);

        // Single-beat ordering
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk(64'h0);
        s_if.tlast  = 1'b1;
        chk("t1_srdy", 64'(s_if.tready), 64'd1);
        step();
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", 64'(m_if.tvalid), 64'd1);
            chk("t1_data", m_if.tdata, 64'(i));
            chk("t1_last", 64'(m_if.tlast), 64'(i == 7));
            step();
        end
        chk("t1_pkt", 64'(packet_count), 64'd1);
        chk("t1_empty", 64'(m_if.tvalid), 64'd0);

        // Fill and backpressure
        m_if.tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = mk(64'(16 * (k + 1)));
            s_if.tlast  = 1'b0;
            chk("t2_acc", 64'(s_if.tready), 64'd1);
            step();
        end
        s_if.tdata = mk(64'h50);
        s_if.tlast = 1'b1;
        chk("t2_full_rdy", 64'(s_if.tready), 64'd0);
        chk("t2_full_lvl", 64'(fifo_level), 64'd4);
        step();
        chk("t2_hold_lvl", 64'(fifo_level), 64'd4);
        chk("t2_hold_rdy", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
        for (int n = 0; n < 32; n++) begin
            chk("t2_valid", 64'(m_if.tvalid), 64'd1);
            chk("t2_data", m_if.tdata, 64'(16 * (n / 8 + 1) + n % 8));
            chk("t2_last", 64'(m_if.tlast), 64'd0);
            if (n == 7) begin
                chk("t2_nopass", 64'(s_if.tready), 64'd0);
            end
            if (n == 8) begin
                chk("t2_rdy3", 64'(s_if.tready), 64'd1);
                chk("t2_lvl3", 64'(fifo_level), 64'd3);
                step();
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end else begin
                step();
            end
        end
        chk("t2_lvl1", 64'(fifo_level), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_b5_data", m_if.tdata, 64'(80 + i));
            chk("t2_b5_last", 64'(m_if.tlast), 64'(i == 7));
            step();
        end
        chk("t2_pkt", 64'(packet_count), 64'd2);
        chk("t2_empty", 64'(m_if.tvalid), 64'd0);

        // Mixed packets under a fixed stall pattern
        m_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = mk(64'(256 * (k + 1)));
            s_if.tlast  = (k != 0);
            step();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("t3_lvl", 64'(fifo_level), 64'd3);
        pat = 64'hA5C3_96F0_3C5A_E187;
        e   = 0;
        for (int c = 0; c < 64; c++) begin
            if (e < 24) begin
                m_if.tready = pat[c];
                chk("t3_valid", 64'(m_if.tvalid), 64'd1);
                chk("t3_data", m_if.tdata, 64'(256 * (e / 8 + 1) + e % 8));
                chk("t3_last", 64'(m_if.tlast),
                    64'((e / 8 != 0) && (e % 8 == 7)));
                hs = m_if.tready;
                step();
                if (hs) e++;
            end
        end
        m_if.tready = 1'b0;
        chk("t3_done", 64'(e), 64'd24);
        chk("t3_pkt", 64'(packet_count), 64'd4);
        chk("t3_lvl0", 64'(fifo_level), 64'd0);

        // Mid-packet flush
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk(64'h400);
        s_if.tlast  = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_pre", m_if.tdata, 64'(1024 + i));
            step();
        end
        chk("t4_idx3", m_if.tdata, 64'h403);
        clr = 1'b1;
        #1;
        chk("t4_clr_rdy", 64'(s_if.tready), 64'd0);
        step();
        clr = 1'b0;
        chk("t4_lvl", 64'(fifo_level), 64'd0);
        chk("t4_valid", 64'(m_if.tvalid), 64'd0);
        chk("t4_data", m_if.tdata, 64'd0);
        chk("t4_pkt", 64'(packet_count), 64'd4);
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk(64'h500);
        step();
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_post_data", m_if.tdata, 64'(1280 + i));
            chk("t4_post_last", 64'(m_if.tlast), 64'd0);
            step();
        end
        chk("t4_empty", 64'(m_if.tvalid), 64'd0);
        chk("t4_pkt2", 64'(packet_count), 64'd4);

        // Pointer wrap with concurrent push/pop
        m_if.tready = 1'b1;
        p = 0;
        e = 0;
        for (int c = 0; c < 200; c++) begin
            if (e < 80) begin
                s_if.tvalid = (p < 10);
                s_if.tdata  = mk(64'(4096 + 16 * p));
                s_if.tlast  = (p == 9);
                chk("t5_lvl_max", 64'(fifo_level <= 3'd4), 64'd1);
                acc = s_if.tvalid && s_if.tready;
                hs  = m_if.tvalid;
                if (hs) begin
                    chk("t5_data", m_if.tdata,
                        64'(4096 + 16 * (e / 8) + e % 8));
                    chk("t5_last", 64'(m_if.tlast), 64'(e == 79));
                end
                step();
                if (acc) p++;
                if (hs) e++;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("t5_drained", 64'(e), 64'd80);
        chk("t5_pushed", 64'(p), 64'd10);
        chk("t5_pkt", 64'(packet_count), 64'd5);
        chk("t5_lvl0", 64'(fifo_level), 64'd0);

        // Asynchronous reset mid-operation
        m_if.tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = mk(64'(8192 + 256 * k));
            step();
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (5) step();
        m_if.tready = 1'b0;
        chk("t6_idx5", m_if.tdata, 64'h2005);
        chk("t6_lvl2", 64'(fifo_level), 64'd2);
`ifdef CMS_DOWNSIZER_STATS_EN
        chk("t6_beats_pre", 64'(beat_count != 0), 64'd1);
        chk("t6_stall_pre", 64'(stall_count != 0), 64'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("t6_a_valid", 64'(m_if.tvalid), 64'd0);
        chk("t6_a_data", m_if.tdata, 64'd0);
        chk("t6_a_last", 64'(m_if.tlast), 64'd0);
        chk("t6_a_lvl", 64'(fifo_level), 64'd0);
        chk("t6_a_pkt", 64'(packet_count), 64'd0);
`ifdef CMS_DOWNSIZER_STATS_EN
        chk("t6_a_beats", 64'(beat_count), 64'd0);
        chk("t6_a_stall", 64'(stall_count), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_rel_rdy", 64'(s_if.tready), 64'd1);
        chk("t6_rel_lvl", 64'(fifo_level), 64'd0);
        chk("t6_rel_valid", 64'(m_if.tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
